// File: rtl/target_access_arbiter.sv
// rtl/target_access_arbiter.sv - two-master round-robin sequencer for a byte-wide bus target
//
// Serializes read/write transactions from two masters onto one target port.
// Writes go out either as one combined address+data strobe or as an address
// phase followed by a data phase. Every transaction is bounded by an ack timeout.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   m_req[1:0]          per-master request, held until that master's m_done
//   m_addr[31:0]        master i address in [16i+15:16i]
//   m_wdata[15:0]       master i write byte in [8i+7:8i]
//   m_rw[1:0]           per-master direction, 1 = write
//   m_grant[1:0]        one-cycle pulse on acceptance
//   m_done[1:0]         one-cycle completion pulse
//   m_err[1:0]          pulses with m_done on timeout
//   m_rdata[7:0]        read byte, valid with m_done, held otherwise
//   s_address_in*, s_data_in*, s_rw   target request side (registered)
//   s_data_out*, s_ack, s_ready       target response side
module target_access_arbiter #(
   parameter int SPLIT_WRITE = 0,
   parameter int TIMEOUT     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  m_req,
   input  logic [31:0] m_addr,
   input  logic [15:0] m_wdata,
   input  logic [1:0]  m_rw,
   output logic [1:0]  m_grant,
   output logic [1:0]  m_done,
   output logic [1:0]  m_err,
   output logic [7:0]  m_rdata,
   output logic [15:0] s_address_in,
   output logic        s_address_in_valid,
   output logic [7:0]  s_data_in,
   output logic        s_data_in_valid,
   output logic        s_rw,
   input  logic [7:0]  s_data_out,
   input  logic        s_data_out_valid,
   input  logic        s_ack,
   input  logic        s_ready
);

   typedef enum logic [1:0] {IDLE, ISSUE, DATA, WAIT} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t      state, state_n;
   logic        ptr, ptr_n;
   logic        win, win_n;
   logic [7:0]  wdata_q, wdata_n;
   logic [7:0]  cnt, cnt_n;

   logic [1:0]  grant_n, done_n, err_n;
   logic [7:0]  rdata_n;
   logic [15:0] addr_n;
   logic        addr_v_n;
   logic [7:0]  data_n;
   logic        data_v_n;
   logic        srw_n;

   // Winner: the pointer master if it requests, otherwise the other one.
   logic        pick;
   logic [15:0] pick_addr;
   logic [7:0]  pick_wdata;

   assign pick       = m_req[ptr] ? ptr : ~ptr;
   assign pick_addr  = pick ? m_addr[31:16] : m_addr[15:0];
   assign pick_wdata = pick ? m_wdata[15:8] : m_wdata[7:0];

   // All outputs are registers; the next-state logic computes the value each
   // output takes during the state being entered. The latched address and
   // direction live directly in s_address_in / s_rw, which hold between phases.
   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      win_n    = win;
      wdata_n  = wdata_q;
      cnt_n    = cnt;
      grant_n  = 2'b00;
      done_n   = 2'b00;
      err_n    = 2'b00;
      rdata_n  = m_rdata;
      addr_n   = s_address_in;
      addr_v_n = 1'b0;
      data_n   = s_data_in;
      data_v_n = 1'b0;
      srw_n    = s_rw;
      case (state)
         IDLE: begin
            if (s_ready && (m_req != 2'b00)) begin
               win_n          = pick;
               ptr_n          = ~pick;
               grant_n[pick]  = 1'b1;
               addr_n         = pick_addr;
               addr_v_n       = 1'b1;
               srw_n          = m_rw[pick];
               wdata_n        = pick_wdata;
               if (m_rw[pick] && (SPLIT_WRITE == 0)) begin
                  data_v_n = 1'b1;
                  data_n   = pick_wdata;
               end
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            cnt_n = 8'd0;
            if (s_rw && (SPLIT_WRITE != 0)) begin
               data_v_n = 1'b1;
               data_n   = wdata_q;
               state_n  = DATA;
            end else begin
               state_n = WAIT;
            end
         end
         DATA: begin
            cnt_n   = 8'd0;
            state_n = WAIT;
         end
         WAIT: begin
            if (s_ack) begin
               done_n[win] = 1'b1;
               // Read data is taken only on the ack cycle so m_rdata never
               // moves outside a done pulse.
               if (!s_rw) begin
                  rdata_n = s_data_out_valid ? s_data_out : 8'd0;
               end
               state_n = IDLE;
            end else if (cnt == LAST_WAIT) begin
               done_n[win] = 1'b1;
               err_n[win]  = 1'b1;
               rdata_n     = 8'd0;
               state_n     = IDLE;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         ptr                <= 1'b0;
         win                <= 1'b0;
         wdata_q            <= 8'd0;
         cnt                <= 8'd0;
         m_grant            <= 2'b00;
         m_done             <= 2'b00;
         m_err              <= 2'b00;
         m_rdata            <= 8'd0;
         s_address_in       <= 16'd0;
         s_address_in_valid <= 1'b0;
         s_data_in          <= 8'd0;
         s_data_in_valid    <= 1'b0;
         s_rw               <= 1'b0;
      end else begin
         state              <= state_n;
         ptr                <= ptr_n;
         win                <= win_n;
         wdata_q            <= wdata_n;
         cnt                <= cnt_n;
         m_grant            <= grant_n;
         m_done             <= done_n;
         m_err              <= err_n;
         m_rdata            <= rdata_n;
         s_address_in       <= addr_n;
         s_address_in_valid <= addr_v_n;
         s_data_in          <= data_n;
         s_data_in_valid    <= data_v_n;
         s_rw               <= srw_n;
      end
   end

endmodule

// File: tb/tb_target_access_arbiter.sv
// tb/tb_target_access_arbiter.sv - self-checking bench for target_access_arbiter
//
// Three instances: 0 = combined writes / TIMEOUT 16, 1 = split writes,
// 2 = TIMEOUT 4. Each drives a 16 x 8 target model with a registered ack.
module tb_target_access_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [3];
   logic [1:0]  m_req     [3];
   logic [31:0] m_addr    [3];
   logic [15:0] m_wdata   [3];
   logic [1:0]  m_rw      [3];
   logic        ready     [3];
   logic        noack     [3];
   logic        force_ack [3];

   logic [1:0]  m_grant            [3];
   logic [1:0]  m_done             [3];
   logic [1:0]  m_err              [3];
   logic [7:0]  m_rdata            [3];
   logic [15:0] s_address_in       [3];
   logic        s_address_in_valid [3];
   logic [7:0]  s_data_in          [3];
   logic        s_data_in_valid    [3];
   logic        s_rw               [3];

   for (genvar k = 0; k < 3; k++) begin : g
      logic       t_ack;
      logic       t_dov;
      logic [7:0] t_dout;
      logic       pend;
      logic [3:0] pa;
      logic [7:0] mem [16];

      // Target: read answers next cycle; write acks the cycle after its data.
      always_ff @(posedge clk) begin
         t_ack <= 1'b0;
         t_dov <= 1'b0;
         if (rst[k]) begin
            pend <= 1'b0;
         end else if (s_address_in_valid[k] && !s_rw[k]) begin
            t_ack  <= !noack[k];
            t_dov  <= 1'b1;
            t_dout <= mem[s_address_in[k][3:0]];
         end else if (s_address_in_valid[k] && s_data_in_valid[k]) begin
            mem[s_address_in[k][3:0]] <= s_data_in[k];
            t_ack <= !noack[k];
         end else if (s_address_in_valid[k]) begin
            pend <= 1'b1;
            pa   <= s_address_in[k][3:0];
         end else if (pend && s_data_in_valid[k]) begin
            mem[pa] <= s_data_in[k];
            t_ack   <= !noack[k];
            pend    <= 1'b0;
         end
      end

      target_access_arbiter #(
         .SPLIT_WRITE((k == 1) ? 1 : 0),
         .TIMEOUT((k == 2) ? 4 : 16)
      ) dut (
         .clk(clk),
         .rst(rst[k]),
         .m_req(m_req[k]),
         .m_addr(m_addr[k]),
         .m_wdata(m_wdata[k]),
         .m_rw(m_rw[k]),
         .m_grant(m_grant[k]),
         .m_done(m_done[k]),
         .m_err(m_err[k]),
         .m_rdata(m_rdata[k]),
         .s_address_in(s_address_in[k]),
         .s_address_in_valid(s_address_in_valid[k]),
         .s_data_in(s_data_in[k]),
         .s_data_in_valid(s_data_in_valid[k]),
         .s_rw(s_rw[k]),
         .s_data_out(t_dout),
         .s_data_out_valid(t_dov),
         .s_ack(t_ack | force_ack[k]),
         .s_ready(ready[k])
      );
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [40:0] outs(input int k);
      return {m_grant[k], m_done[k], m_err[k], m_rdata[k], s_address_in[k],
              s_address_in_valid[k], s_data_in[k], s_data_in_valid[k], s_rw[k]};
   endfunction

   // Results of the last run_txn; times are cycles after the request was raised.
   int          r_tg, r_td, r_tdv;
   logic [1:0]  r_gv, r_dn, r_ev;
   logic [7:0]  r_rd, r_di;
   logic [15:0] r_ga;

   task automatic run_txn(input int k, input int mst, input logic rw,
                          input logic [15:0] addr, input logic [7:0] wd);
      r_tg = -1; r_td = -1; r_tdv = -1;
      r_gv = 0; r_dn = 0; r_ev = 0; r_rd = 0; r_di = 0; r_ga = 0;
      m_addr[k][16*mst +: 16] = addr;
      m_wdata[k][8*mst +: 8]  = wd;
      m_rw[k][mst]            = rw;
      m_req[k][mst]           = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (m_grant[k] != 2'b00 && r_tg < 0) begin
            r_tg = n; r_gv = m_grant[k]; r_ga = s_address_in[k];
            m_req[k][mst] = 1'b0;
         end
         if (s_data_in_valid[k] && r_tdv < 0) begin
            r_tdv = n; r_di = s_data_in[k];
         end
         if (m_done[k] != 2'b00) begin
            r_td = n; r_dn = m_done[k]; r_ev = m_err[k]; r_rd = m_rdata[k];
            break;
         end
      end
      m_req[k][mst] = 1'b0;
   endtask

   typedef struct {
      int          mst;
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_rdata;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [1:0] acc;
      logic [1:0] eg;
      logic [1:0] ed;

      tbl[0] = '{0, 1'b1, 16'h0003, 8'hA5, 8'h00};
      tbl[1] = '{0, 1'b0, 16'h0003, 8'h00, 8'hA5};
      tbl[2] = '{1, 1'b1, 16'h0007, 8'h5A, 8'h00};
      tbl[3] = '{1, 1'b0, 16'h0007, 8'h00, 8'h5A};
      tbl[4] = '{0, 1'b0, 16'h0007, 8'h00, 8'h5A};
      tbl[5] = '{1, 1'b1, 16'h0001, 8'h11, 8'h00};
      tbl[6] = '{0, 1'b1, 16'h0002, 8'h22, 8'h00};
      tbl[7] = '{1, 1'b0, 16'h0002, 8'h00, 8'h22};

      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; m_req[k] = 0; m_addr[k] = 0; m_wdata[k] = 0; m_rw[k] = 0;
         ready[k] = 1'b1; noack[k] = 1'b0; force_ack[k] = 1'b0;
      end
      @(negedge clk); @(negedge clk);
      for (int k = 0; k < 3; k++) chk($sformatf("reset_outs%0d", k), outs(k), 0);
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      @(negedge clk);

      // Combined-write instance: table of single transactions.
      for (int i = 0; i < 8; i++) begin
         run_txn(0, tbl[i].mst, tbl[i].rw, tbl[i].addr, tbl[i].wdata);
         chk($sformatf("v%0d_grant_time", i), r_tg, 1);
         chk($sformatf("v%0d_grant_vec", i), r_gv, 1 << tbl[i].mst);
         chk($sformatf("v%0d_addr", i), r_ga, tbl[i].addr);
         chk($sformatf("v%0d_done_time", i), r_td, 3);
         chk($sformatf("v%0d_done_vec", i), r_dn, 1 << tbl[i].mst);
         chk($sformatf("v%0d_err", i), r_ev, 0);
         if (tbl[i].rw) chk($sformatf("v%0d_wdata_time", i), r_tdv, 1);
         else           chk($sformatf("v%0d_rdata", i), r_rd, tbl[i].exp_rdata);
      end

      // Ack outside WAIT produces no done.
      force_ack[0] = 1'b1;
      @(negedge clk);
      force_ack[0] = 1'b0;
      acc = 0;
      for (int n = 0; n < 2; n++) begin @(negedge clk); acc |= m_done[0]; end
      chk("stray_ack_done", acc, 0);

      // Not ready: no grant for 5 cycles, grant one cycle after s_ready rises.
      ready[0] = 1'b0;
      m_addr[0][15:0] = 16'h0003; m_rw[0][0] = 1'b0; m_req[0][0] = 1'b1;
      acc = 0;
      for (int n = 0; n < 5; n++) begin @(negedge clk); acc |= m_grant[0]; end
      chk("notready_grant", acc, 0);
      ready[0] = 1'b1;
      @(negedge clk);
      chk("ready_grant", m_grant[0], 2'b01);
      m_req[0][0] = 1'b0;
      for (int n = 0; n < 10 && m_done[0] == 0; n++) @(negedge clk);
      chk("ready_rdata", m_rdata[0], 8'hA5);

      // Simultaneous held reads from reset alternate m0, m1, m0.
      @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      m_addr[0] = {16'h0002, 16'h0001}; m_rw[0] = 2'b00; m_req[0] = 2'b11;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         eg = (n == 1 || n == 7) ? 2'b01 : (n == 4) ? 2'b10 : 2'b00;
         ed = (n == 3 || n == 9) ? 2'b01 : (n == 6) ? 2'b10 : 2'b00;
         chk($sformatf("rr_grant_c%0d", n), m_grant[0], eg);
         chk($sformatf("rr_done_c%0d", n), m_done[0], ed);
         if (ed != 0) chk($sformatf("rr_rdata_c%0d", n), m_rdata[0], (n == 6) ? 8'h22 : 8'h11);
         if (n == 9) m_req[0] = 2'b00;
      end
      @(negedge clk);
      chk("rr_no_extra_grant", m_grant[0], 0);

      // Split-write instance.
      run_txn(1, 1, 1'b1, 16'h000F, 8'h3C);
      chk("split_grant_time", r_tg, 1);
      chk("split_grant_vec", r_gv, 2'b10);
      chk("split_data_time", r_tdv, 2);
      chk("split_data_val", r_di, 8'h3C);
      chk("split_done_time", r_td, 4);
      chk("split_done_vec", r_dn, 2'b10);
      run_txn(1, 0, 1'b0, 16'h000F, 8'h00);
      chk("split_rd_time", r_td, 3);
      chk("split_rd_data", r_rd, 8'h3C);

      // Timeout instance (TIMEOUT = 4).
      run_txn(2, 0, 1'b1, 16'h0005, 8'h77);
      chk("to_wr_time", r_td, 3);
      run_txn(2, 0, 1'b0, 16'h0005, 8'h00);
      chk("to_rd1_data", r_rd, 8'h77);
      noack[2] = 1'b1;
      run_txn(2, 0, 1'b0, 16'h0005, 8'h00);
      chk("to_done_time", r_td, 6);
      chk("to_done_vec", r_dn, 2'b01);
      chk("to_err_vec", r_ev, 2'b01);
      chk("to_rdata_zero", r_rd, 8'h00);
      noack[2] = 1'b0;
      run_txn(2, 1, 1'b0, 16'h0005, 8'h00);
      chk("to_after_time", r_td, 3);
      chk("to_after_err", r_ev, 0);
      chk("to_after_data", r_rd, 8'h77);

      // Reset during WAIT.
      noack[2] = 1'b1;
      m_addr[2][15:0] = 16'h0005; m_rw[2][0] = 1'b0; m_req[2][0] = 1'b1;
      @(negedge clk);
      chk("rst_seq_grant", m_grant[2], 2'b01);
      m_req[2][0] = 1'b0;
      @(negedge clk); @(negedge clk);
      rst[2] = 1'b1;
      #1;
      chk("rst_mid_outs", outs(2), 0);
      @(negedge clk);
      rst[2] = 1'b0; noack[2] = 1'b0;
      acc = 0;
      for (int n = 0; n < 8; n++) begin @(negedge clk); acc |= m_done[2]; end
      chk("rst_no_done", acc, 0);
      m_addr[2] = {16'h0006, 16'h0005}; m_rw[2] = 2'b00; m_req[2] = 2'b11;
      @(negedge clk);
      chk("rst_first_grant", m_grant[2], 2'b01);
      m_req[2] = 2'b00;
      acc = 0;
      for (int n = 0; n < 10 && acc == 0; n++) begin @(negedge clk); acc = m_done[2]; end
      chk("rst_after_done", acc, 2'b01);
      chk("rst_after_data", m_rdata[2], 8'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
